// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory responder: MMIO offsets, window span and request type.
package dmem_mmio_pkg;

  localparam logic [5:0] OFF_IN0   = 6'h00;
  localparam logic [5:0] OFF_IN1   = 6'h04;
  localparam logic [5:0] OFF_IN2   = 6'h08;
  localparam logic [5:0] OFF_OUT0  = 6'h10;
  localparam logic [5:0] OFF_OUT1  = 6'h14;
  localparam logic [5:0] OFF_OUT2  = 6'h18;
  localparam logic [5:0] OFF_CYCLE = 6'h20;

  localparam int MMIO_SPAN = 64;

  typedef enum logic {
    DMEM_RD = 1'b0,
    DMEM_WR = 1'b1
  } dmem_type_e;

endpackage

// File: rtl/mmio_cycle_counter.sv
// Free-running 32-bit cycle counter; a load takes priority over the increment.
module mmio_cycle_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_en,
  input  logic [31:0] ld_data,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       count <= '0;
    else if (ld_en) count <= ld_data;
    else            count <= count + 32'd1;
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Same-cycle data-memory responder: word RAM plus a 64-byte MMIO window behind one decoder.
// Define DMEM_MMIO_CYCLE_CNT_EN to map a cycle counter at MMIO offset 0x20.
module dmem_mmio_responder
  import dmem_mmio_pkg::*;
#(
  parameter int          RAM_WORDS = 256,
  parameter logic [31:0] MMIO_BASE = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmemreq_val,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic [31:0] dmemresp_rdata,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out0,
  output logic [31:0] out1,
  output logic [31:0] out2,
  output logic        err
);

  localparam int          AW         = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_LIMIT  = 32'(RAM_WORDS * 4);
  localparam logic [31:0] MMIO_LIMIT = MMIO_BASE + 32'(MMIO_SPAN);

  logic [31:0]   ram [RAM_WORDS];
  logic          is_rd, is_wr, ram_hit, mmio_hit, reg_hit, unmapped;
  logic [5:0]    off;
  logic [AW-1:0] ram_idx;
  logic [31:0]   mmio_rdata;

`ifdef DMEM_MMIO_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
  logic        cyc_ld;

  assign cyc_ld = is_wr && mmio_hit && (off == OFF_CYCLE);

  mmio_cycle_counter u_cycle_counter (
    .clk     (clk),
    .rst     (rst),
    .ld_en   (cyc_ld),
    .ld_data (dmemreq_wdata),
    .count   (cycle_cnt)
  );
`endif

  // RAM takes precedence where a large RAM would overlap the MMIO window.
  always_comb begin
    is_rd      = dmemreq_val && (dmem_type_e'(dmemreq_type) == DMEM_RD);
    is_wr      = dmemreq_val && (dmem_type_e'(dmemreq_type) == DMEM_WR);
    ram_hit    = dmemreq_addr < RAM_LIMIT;
    mmio_hit   = !ram_hit && (dmemreq_addr >= MMIO_BASE) && (dmemreq_addr < MMIO_LIMIT);
    off        = {dmemreq_addr[5:2], 2'b00};
    ram_idx    = dmemreq_addr[AW+1:2];
    reg_hit    = 1'b0;
    mmio_rdata = '0;
    if (mmio_hit) begin
      case (off)
        OFF_IN0:  begin reg_hit = 1'b1; mmio_rdata = in0;  end
        OFF_IN1:  begin reg_hit = 1'b1; mmio_rdata = in1;  end
        OFF_IN2:  begin reg_hit = 1'b1; mmio_rdata = in2;  end
        OFF_OUT0: begin reg_hit = 1'b1; mmio_rdata = out0; end
        OFF_OUT1: begin reg_hit = 1'b1; mmio_rdata = out1; end
        OFF_OUT2: begin reg_hit = 1'b1; mmio_rdata = out2; end
`ifdef DMEM_MMIO_CYCLE_CNT_EN
        OFF_CYCLE: begin reg_hit = 1'b1; mmio_rdata = cycle_cnt; end
`endif
        default: ;
      endcase
    end
    unmapped = dmemreq_val && !ram_hit && !reg_hit;
  end

  always_comb begin
    dmemresp_rdata = '0;
    if (is_rd) begin
      if (ram_hit)      dmemresp_rdata = ram[ram_idx];
      else if (reg_hit) dmemresp_rdata = mmio_rdata;
    end
  end

  // RAM has no reset, so writes arriving while reset is held must be blocked explicitly.
  always_ff @(posedge clk) begin
    if (is_wr && ram_hit && rst) ram[ram_idx] <= dmemreq_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out0 <= '0;
      out1 <= '0;
      out2 <= '0;
      err  <= 1'b0;
    end else begin
      if (unmapped) err <= 1'b1;
      if (is_wr && mmio_hit) begin
        case (off)
          OFF_OUT0: out0 <= dmemreq_wdata;
          OFF_OUT1: out1 <= dmemreq_wdata;
          OFF_OUT2: out2 <= dmemreq_wdata;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed and randomized check of dmem_mmio_responder against an address-map model.
module tb_dmem_mmio_responder;

  localparam int          RAM_WORDS = 256;
  localparam logic [31:0] MMIO_BASE = 32'h0000_2000;
`ifdef DMEM_MMIO_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dmemreq_val = 1'b0;
  logic        dmemreq_type = 1'b0;
  logic [31:0] dmemreq_addr = '0;
  logic [31:0] dmemreq_wdata = '0;
  logic [31:0] dmemresp_rdata;
  logic [31:0] in0 = 32'h1111_0000, in1 = 32'h2222_0000, in2 = 32'h3333_0000;
  logic [31:0] out0, out1, out2;
  logic        err;

  int tests = 0;
  int fails = 0;
  int unsigned edges = 0;

  logic [31:0] ram_m [int unsigned];
  logic [31:0] out_m [3];
  logic        err_m = 1'b0;
  logic [31:0] cnt_base = '0;
  int unsigned cnt_edge = 0;

  dmem_mmio_responder #(.RAM_WORDS(RAM_WORDS), .MMIO_BASE(MMIO_BASE)) dut (
    .clk(clk), .rst(rst), .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type),
    .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
    .dmemresp_rdata(dmemresp_rdata), .in0(in0), .in1(in1), .in2(in2),
    .out0(out0), .out1(out1), .out2(out2), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // kind: 0 RAM, 1 input word, 2 output register, 3 counter, 4 unmapped
  function automatic void decode(input logic [31:0] a, output int kind, output int unsigned idx);
    int unsigned w;
    kind = 4;
    idx  = 0;
    if (a < RAM_WORDS * 4) begin
      kind = 0; idx = a / 4;
    end else if (a >= MMIO_BASE && (a - MMIO_BASE) < 64) begin
      w = (a - MMIO_BASE) / 4;
      if (w < 3)                 begin kind = 1; idx = w;     end
      else if (w >= 4 && w < 7)  begin kind = 2; idx = w - 4; end
      else if (w == 8 && CNT_EN) kind = 3;
    end
  endfunction

  function automatic logic [31:0] in_word(input int unsigned i);
    return (i == 0) ? in0 : (i == 1) ? in1 : in2;
  endfunction

  task automatic check_regs(input string tag);
    check({tag, "_out0"}, out0, out_m[0]);
    check({tag, "_out1"}, out1, out_m[1]);
    check({tag, "_out2"}, out2, out_m[2]);
    check({tag, "_err"}, {31'b0, err}, {31'b0, err_m});
  endtask

  task automatic op(input logic wr, input logic [31:0] a, input logic [31:0] d, input string tag);
    int kind;
    int unsigned idx;
    logic [31:0] exp;
    bit known;
    decode(a, kind, idx);
    @(negedge clk);
    dmemreq_val = 1'b1; dmemreq_type = wr; dmemreq_addr = a; dmemreq_wdata = d;
    #1;
    known = 1'b1;
    exp   = '0;
    if (!wr) begin
      case (kind)
        0: if (ram_m.exists(idx)) exp = ram_m[idx]; else known = 1'b0;
        1: exp = in_word(idx);
        2: exp = out_m[idx];
        3: exp = cnt_base + (edges - cnt_edge);
        default: exp = '0;
      endcase
    end
    if (known) check({tag, "_rdata"}, dmemresp_rdata, exp);
    @(posedge clk);
    #1;
    dmemreq_val = 1'b0;
    if (wr) begin
      case (kind)
        0: ram_m[idx] = d;
        2: out_m[idx] = d;
        3: begin cnt_base = d; cnt_edge = edges; end
        default: ;
      endcase
    end
    if (kind == 4) err_m = 1'b1;
    check_regs(tag);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    dmemreq_val = 1'b0;
    dmemreq_addr = $urandom;
    #1;
    check({tag, "_rdata"}, dmemresp_rdata, 32'h0);
    check({tag, "_err"}, {31'b0, err}, {31'b0, err_m});
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    out_m[0] = '0; out_m[1] = '0; out_m[2] = '0; err_m = 1'b0;
    #1;
    check_regs({tag, "_async"});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cnt_base = '0;
    cnt_edge = edges;
  endtask

  initial begin
    logic [31:0] a;
    int unsigned sel;
    out_m[0] = '0; out_m[1] = '0; out_m[2] = '0;
    repeat (3) @(posedge clk);
    check_regs("reset_hold");
    @(negedge clk);
    rst = 1'b1;
    cnt_edge = edges;
    idle("idle0");
    idle("idle1");

    op(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "ram_wr");
    op(1'b0, 32'h0000_0010, 32'h0, "ram_rd");
    op(1'b0, 32'h0000_0013, 32'h0, "ram_rd_unaligned");
    op(1'b1, MMIO_BASE + 32'h14, 32'h0000_00AB, "out1_wr");
    check("out1_val", out1, 32'h0000_00AB);
    in2 = 32'h0000_1234;
    op(1'b0, MMIO_BASE + 32'h08, 32'h0, "in2_rd");
    op(1'b1, MMIO_BASE + 32'h00, 32'hFFFF_0000, "in0_wr_ignored");
    op(1'b0, MMIO_BASE + 32'h00, 32'h0, "in0_rd");
    op(1'b0, MMIO_BASE + 32'h10, 32'h0, "out0_rd");

    op(1'b0, 32'h0000_8000, 32'h0, "unmapped_rd");
    check("unmapped_err", {31'b0, err}, 32'h1);
    for (int i = 0; i < 10; i++) idle("err_sticky");
    do_reset("rst_err");
    check("err_cleared", {31'b0, err}, 32'h0);

`ifdef DMEM_MMIO_CYCLE_CNT_EN
    repeat (5) @(posedge clk);
    op(1'b0, MMIO_BASE + 32'h20, 32'h0, "cnt_cycle5");
    check("cnt_no_err", {31'b0, err}, 32'h0);
    op(1'b1, MMIO_BASE + 32'h20, 32'hFFFF_FFFE, "cnt_ld");
    @(negedge clk);
    dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = MMIO_BASE + 32'h20;
    #1 check("cnt_wrap0", dmemresp_rdata, 32'hFFFF_FFFE);
    @(negedge clk); #1 check("cnt_wrap1", dmemresp_rdata, 32'hFFFF_FFFF);
    @(negedge clk); #1 check("cnt_wrap2", dmemresp_rdata, 32'h0000_0000);
    dmemreq_val = 1'b0;
`else
    op(1'b0, MMIO_BASE + 32'h20, 32'h0, "cnt_absent_rd");
    check("cnt_absent_err", {31'b0, err}, 32'h1);
`endif
    do_reset("rst_pre_rand");

    for (int i = 0; i < 32; i++) op(1'b1, i * 4, $urandom, "ram_init");
    op(1'b1, (RAM_WORDS - 1) * 4, $urandom, "ram_init_top");

    for (int i = 0; i < 400; i++) begin
      if ((i % 8) == 0) begin in0 = $urandom; in1 = $urandom; in2 = $urandom; end
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        a = ($urandom_range(0, 8) == 0) ? (RAM_WORDS - 1) * 4 : $urandom_range(0, 31) * 4;
        a = a + $urandom_range(0, 3);
      end else if (sel < 9) begin
        a = MMIO_BASE + $urandom_range(0, 63);
      end else if ($urandom_range(0, 1) == 0) begin
        a = RAM_WORDS * 4 + $urandom_range(0, MMIO_BASE - RAM_WORDS * 4 - 1);
      end else begin
        a = MMIO_BASE + 64 + $urandom_range(0, 32'h00FF_FFFF);
      end
      op(1'($urandom_range(0, 1)), a, $urandom, "rand");
      if ((i % 100) == 99) do_reset("rand_rst");
    end

    op(1'b1, MMIO_BASE + 32'h18, 32'h0000_55AA, "out2_pre");
    @(negedge clk);
    dmemreq_val = 1'b1; dmemreq_type = 1'b1;
    dmemreq_addr = MMIO_BASE + 32'h18; dmemreq_wdata = 32'h1111_2222;
    #1 rst = 1'b0;
    #1 check("midwr_rst_out2", out2, 32'h0);
    @(posedge clk);
    #1 check("midwr_hold_out2", out2, 32'h0);
    @(negedge clk);
    dmemreq_val = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 check("midwr_release_out2", out2, 32'h0);
    check("midwr_release_err", {31'b0, err}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
# dmem_mmio_responder

Responder end of the processor data-memory interface: accepts `dmemreq_*` requests from the single-cycle processor and returns `dmemresp_rdata` in the same cycle. Word-addressed RAM and a memory-mapped I/O window sit behind one decoder. The MMIO window exposes the `in0`–`in2` inputs, the `out0`–`out2` output registers and an optional free-running cycle counter. The block replaces the data half of the test memory in synthesized builds.

## Interface
- `RAM_WORDS`, 256: number of 32-bit RAM words (power of two, 16..4096)
- `MMIO_BASE`, 32'h0000_2000: base byte address of the MMIO window (64-byte aligned)
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `dmemreq_val`  in  1  request valid this cycle
- `dmemreq_type`  in  1  0 = read, 1 = write
- `dmemreq_addr`  in  32  byte address; bits [1:0] ignored
- `dmemreq_wdata`  in  32  store data
- `dmemresp_rdata`  out  32  load data, combinational from request
- `in0`, `in1`, `in2`  in  32 each  external input words, sampled combinationally on read
- `out0`, `out1`, `out2`  out  32 each  MMIO output registers
- `err`  out  1  sticky flag: an access hit an unmapped address

## Operation
- Decode, with word index w = addr[31:2]:
  - RAM if addr < RAM_WORDS*4.
  - MMIO if MMIO_BASE <= addr < MMIO_BASE+64.
  - Anything else is unmapped.
- MMIO offsets:
  - 0x00 in0, 0x04 in1, 0x08 in2: read-only; writes ignored, not an error.
  - 0x10 out0, 0x14 out1, 0x18 out2: read/write.
  - 0x20 cycle counter: read/write, present only with the macro.
  - All other offsets are unmapped.
- Read (val=1, type=0): rdata = selected word. Unmapped reads return 32'h0 and set `err`.
- Write (val=1, type=1): the selected RAM word or out register takes wdata at the next edge. Unmapped writes are dropped and set `err`.
- No request (val=0), or any write: rdata = 32'h0.
- `err` clears only on reset.
- Cycle counter: 32-bit, increments by 1 every cycle. Wraps from 32'hFFFF_FFFF to 0.
  - A write to the counter has priority over the increment: the next value is wdata, not wdata+1.

## Timing
- Reset (rst=0, async):
  - out0/out1/out2 = 0, `err` = 0, counter = 0.
  - RAM contents are not reset (undefined until written).
  - During reset, writes are ignored and reads still decode combinationally.
- Read latency: 0 cycles (same-cycle response, no handshake, no stall). Write latency: 1 edge.
- A read in the cycle after a write to the same address returns the new data. A read in the same cycle as the write returns the old data; this cannot occur with a single-port request.
- First counter read after reset deassertion returns the number of completed rising edges since deassertion (0 in the first cycle).
- Reset asserted mid-write: the write is lost and registers go to reset values immediately.

## Configuration
- `DMEM_MMIO_CYCLE_CNT_EN` defined: the counter is instantiated at offset 0x20 with the behaviour above.
- Macro undefined: no counter flops; offset 0x20 is unmapped (reads 0, sets `err`).

## Structure
- Package `dmem_mmio_pkg` holds:
  - offset constants (`OFF_IN0`…`OFF_CYCLE`);
  - `MMIO_SPAN` = 64;
  - enum `dmem_type_e` {DMEM_RD=0, DMEM_WR=1}.
- One sub-module, `mmio_cycle_counter` (clk, rst, ld_en, ld_data, count): instantiated only under the macro.
- Top level contains the decoder, RAM array, out registers and read mux.

## Test plan
- Reset then idle: out0..out2 = 0, err = 0, rdata = 0 with val=0.
- Write 0xDEADBEEF to 0x0000_0010, read 0x0000_0010 next cycle -> rdata 0xDEADBEEF. Read 0x0000_0013 -> same word.
- Write 0x0000_00AB to MMIO_BASE+0x14 -> out1 = 0xAB after the edge. in2 = 0x1234 with read at MMIO_BASE+0x08 -> 0x1234. Write to MMIO_BASE+0x00 -> in0 unchanged, err stays 0.
- Read 0x0000_8000 (unmapped) -> rdata 0, err = 1 and stays 1 across 10 idle cycles. Reset -> err = 0.
- Macro on: after reset release, read 0x20 at cycle 5 -> 5. Write 0xFFFF_FFFE -> next reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- Macro off: read MMIO_BASE+0x20 -> 0, err = 1. Assert rst during a write to out2 -> out2 = 0 immediately and stays 0 after release.
